// File: rtl/mram_1r1w_be_clr.sv
// One-read/one-write RAM with per-byte write enables, write-first forwarding and read-data hold.
// A clear engine zeroes the array after reset or on CLR; OREG adds a second output stage.
module mram_1r1w_be_clr #(
   parameter int P_DW = 6,
   parameter int AW   = 6,
   parameter int OREG = 0
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     CLR,
   output logic                     BUSY,
   input  logic                     RE,
   input  logic [AW-1:0]            RADDR,
   output logic [(1<<P_DW)-1:0]     DOUT,
   output logic                     DOUT_VALID,
   input  logic [(1<<P_DW)/8-1:0]   WE,
   input  logic [AW-1:0]            WADDR,
   input  logic [(1<<P_DW)-1:0]     DIN
);

   localparam int DW    = 1 << P_DW;
   localparam int NB    = DW / 8;
   localparam int DEPTH = 1 << AW;
   localparam logic [AW-1:0] LAST = '1;

   typedef enum logic {INIT, RUN} state_t;

   state_t          state;
   logic [AW-1:0]   cnt;
   logic [DW-1:0]   mem [DEPTH];
   logic [DW-1:0]   stage1;
   logic [DW-1:0]   rd_next;
   logic            vld1;
   logic            rd_acc;

   assign BUSY   = (state == INIT);
   assign rd_acc = RE & ~BUSY;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         case (state)
            INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= RUN;
            end
            RUN: begin
               if (CLR) begin
                  state <= INIT;
                  cnt   <= '0;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   // The array itself carries no reset; INIT sweeps zeros through it instead.
   always_ff @(posedge CLK) begin
      if (BUSY) begin
         mem[cnt] <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (WE[b]) mem[WADDR][b*8 +: 8] <= DIN[b*8 +: 8];
         end
      end
   end

   // Write-first forwarding, resolved byte by byte.
   always_comb begin
      rd_next = mem[RADDR];
      for (int b = 0; b < NB; b++) begin
         if (WE[b] && (WADDR == RADDR)) rd_next[b*8 +: 8] = DIN[b*8 +: 8];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stage1 <= '0;
         vld1   <= 1'b0;
      end else begin
         vld1 <= rd_acc;
         if (rd_acc) stage1 <= rd_next;
      end
   end

   generate
      if (OREG != 0) begin : g_oreg
         logic [DW-1:0] stage2;
         logic          vld2;
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               stage2 <= '0;
               vld2   <= 1'b0;
            end else begin
               stage2 <= stage1;
               vld2   <= vld1;
            end
         end
         assign DOUT       = stage2;
         assign DOUT_VALID = vld2;
      end else begin : g_noreg
         assign DOUT       = stage1;
         assign DOUT_VALID = vld1;
      end
   endgenerate

endmodule

// File: tb/tb_mram_1r1w_be_clr.sv
// Directed bench: two instances (OREG=0 and OREG=1) share all inputs and are checked
// against hand-computed tables and sequences for clear, byte writes, forwarding and hold.
module tb_mram_1r1w_be_clr;

   logic        clk;
   logic        rst;
   logic        clr;
   logic        re;
   logic [3:0]  raddr;
   logic [7:0]  we;
   logic [3:0]  waddr;
   logic [63:0] din;
   logic        busy0, busy1;
   logic [63:0] dout0, dout1;
   logic        dv0, dv1;

   int n_cmp = 0;
   int n_err = 0;

   mram_1r1w_be_clr #(.P_DW(6), .AW(4), .OREG(0)) u0 (
      .CLK(clk), .RST(rst), .CLR(clr), .BUSY(busy0), .RE(re), .RADDR(raddr),
      .DOUT(dout0), .DOUT_VALID(dv0), .WE(we), .WADDR(waddr), .DIN(din));

   mram_1r1w_be_clr #(.P_DW(6), .AW(4), .OREG(1)) u1 (
      .CLK(clk), .RST(rst), .CLR(clr), .BUSY(busy1), .RE(re), .RADDR(raddr),
      .DOUT(dout1), .DOUT_VALID(dv1), .WE(we), .WADDR(waddr), .DIN(din));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        re;
      logic [3:0]  raddr;
      logic [7:0]  we;
      logic [3:0]  waddr;
      logic [63:0] din;
      logic [63:0] exp_d;
      logic        exp_v;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clr = 0; re = 0; raddr = 0; we = 0; waddr = 0; din = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [63:0] pd;
      logic        pv;

      idle();
      rst = 1;
      tick(); tick();
      chk("rst_busy0", 64'(busy0), 64'd1);
      chk("rst_busy1", 64'(busy1), 64'd1);
      chk("rst_dout0", dout0, 64'd0);
      chk("rst_dv0",   64'(dv0), 64'd0);
      chk("rst_dout1", dout1, 64'd0);

      // Release and count cycles with BUSY high, probing reads that must be ignored.
      rst = 0;
      re = 1; raddr = 2;
      n = 0;
      while (busy0 && n < 40) begin
         n++;
         tick();
         chk("init_no_dv", 64'(dv0), 64'd0);
      end
      chk("init_busy_len", 64'(n), 64'd16);
      idle();

      for (int a = 0; a < 16; a++) begin
         re = 1; raddr = 4'(a);
         tick();
         chk("clr_read_d", dout0, 64'd0);
         chk("clr_read_v", 64'(dv0), 64'd1);
      end
      idle();
      tick();

      //            re raddr we     waddr din                     exp_d                   exp_v
      tbl[0]  = '{1, 0,  8'h00, 0, 64'h0,                  64'h0,                  1};
      tbl[1]  = '{1, 15, 8'h00, 0, 64'h0,                  64'h0,                  1};
      tbl[2]  = '{0, 0,  8'hFF, 3, 64'h1122334455667788,   64'h0,                  0};
      tbl[3]  = '{0, 0,  8'h03, 3, 64'h000000000000AAAA,   64'h0,                  0};
      tbl[4]  = '{1, 3,  8'h00, 0, 64'h0,                  64'h112233445566AAAA,   1};
      tbl[5]  = '{1, 5,  8'hF0, 5, 64'hDEADBEEFCAFEF00D,   64'hDEADBEEF00000000,   1};
      tbl[6]  = '{1, 4,  8'hFF, 6, 64'h0123456789ABCDEF,   64'h0,                  1};
      tbl[7]  = '{0, 0,  8'h00, 0, 64'h0,                  64'h0,                  0};
      tbl[8]  = '{1, 6,  8'h00, 0, 64'h0,                  64'h0123456789ABCDEF,   1};
      tbl[9]  = '{1, 5,  8'h00, 0, 64'h0,                  64'hDEADBEEF00000000,   1};
      tbl[10] = '{0, 0,  8'hFF, 3, 64'hFFFFFFFFFFFFFFFF,   64'hDEADBEEF00000000,   0};
      tbl[11] = '{0, 0,  8'h00, 0, 64'h0,                  64'hDEADBEEF00000000,   0};
      tbl[12] = '{1, 3,  8'h00, 0, 64'h0,                  64'hFFFFFFFFFFFFFFFF,   1};
      tbl[13] = '{1, 9,  8'h01, 9, 64'h1234567812345655,   64'h0000000000000055,   1};
      tbl[14] = '{0, 0,  8'h00, 0, 64'h0,                  64'h0000000000000055,   0};

      pd = 64'h0; pv = 0;
      for (int i = 0; i < 15; i++) begin
         re = tbl[i].re; raddr = tbl[i].raddr; we = tbl[i].we;
         waddr = tbl[i].waddr; din = tbl[i].din;
         tick();
         chk($sformatf("vec%0d_d0", i), dout0, tbl[i].exp_d);
         chk($sformatf("vec%0d_v0", i), 64'(dv0), 64'(tbl[i].exp_v));
         chk($sformatf("vec%0d_d1", i), dout1, pd);
         chk($sformatf("vec%0d_v1", i), 64'(dv1), 64'(pv));
         pd = tbl[i].exp_d; pv = tbl[i].exp_v;
      end
      idle();

      // OREG=1 latency and hold while addr 3 keeps being rewritten.
      re = 1; raddr = 3;
      tick();
      chk("hold_lat1_v1", 64'(dv1), 64'd0);
      re = 0; we = 8'hFF; waddr = 3; din = 64'h0;
      tick();
      chk("hold_lat2_d1", dout1, 64'hFFFFFFFFFFFFFFFF);
      chk("hold_lat2_v1", 64'(dv1), 64'd1);
      for (int k = 0; k < 5; k++) begin
         din = 64'(k + 1) * 64'h0101010101010101;
         tick();
         chk("hold_d1", dout1, 64'hFFFFFFFFFFFFFFFF);
         chk("hold_v1", 64'(dv1), 64'd0);
      end
      idle();

      for (int a = 0; a < 16; a++) begin
         we = 8'hFF; waddr = 4'(a); din = 64'(a);
         tick();
      end
      idle();

      clr = 1; re = 1; raddr = 7;
      tick();
      clr = 0; raddr = 0;
      chk("clr_cyc_d0", dout0, 64'd7);
      chk("clr_cyc_v0", 64'(dv0), 64'd1);
      chk("clr_cyc_busy", 64'(busy0), 64'd1);
      n = 1;
      tick();
      chk("clr_cyc_d1", dout1, 64'd7);
      chk("clr_cyc_v1", 64'(dv1), 64'd1);
      chk("clr_busy_no_dv0", 64'(dv0), 64'd0);
      while (busy0 && n < 40) begin
         n++;
         tick();
         chk("clr_busy_no_dv0", 64'(dv0), 64'd0);
         chk("clr_busy_no_dv1", 64'(dv1), 64'd0);
      end
      chk("clr_busy_len", 64'(n), 64'd16);
      idle();
      re = 1; raddr = 7;
      tick();
      chk("post_clr_7", dout0, 64'd0);
      chk("post_clr_7v", 64'(dv0), 64'd1);
      raddr = 15;
      tick();
      chk("post_clr_15", dout0, 64'd0);
      idle();

      // Reset lands when the clear counter has reached 9.
      clr = 1;
      tick();
      clr = 0;
      for (int k = 0; k < 9; k++) tick();
      chk("mid_busy_pre", 64'(busy0), 64'd1);
      rst = 1;
      #1;
      chk("mid_rst_busy", 64'(busy0), 64'd1);
      chk("mid_rst_dout", dout0, 64'd0);
      chk("mid_rst_cnt", 64'(u0.cnt), 64'd0);
      tick(); tick();
      rst = 0;
      n = 0;
      while (busy0 && n < 40) begin
         n++;
         tick();
         chk("mid_dout0", dout0, 64'd0);
         chk("mid_dout1", dout1, 64'd0);
      end
      chk("mid_busy_len", 64'(n), 64'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mram_1r1w_be_clr.md
# mRAM_1r1w_be_clr

Parametrised single-clock simple-dual-port (one read, one write) RAM with byte-enable writes, same-cycle write-to-read forwarding, read-data hold and an optional output pipeline register. A built-in clear engine zeroes every entry after reset or on request, so users see deterministic contents without a software init loop. It is the drop-in storage primitive for cache tag/data arrays, branch-predictor tables and TLBs that need concurrent lookup and fill.

## Interface
- P_DW, 6, log2 of data width in bits; ≥3 (width = 1<<P_DW, bytes = (1<<P_DW)/8)
- AW, 6, address width; depth = 1<<AW entries
- OREG, 0, 0: read latency 1; 1: extra output register, read latency 2
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- CLR  in  1  synchronous request to re-zero the whole array
- BUSY  out  1  clear engine running; RE/WE ignored
- RE  in  1  read enable
- RADDR  in  AW  read address
- DOUT  out  1<<P_DW  read data
- DOUT_VALID  out  1  DOUT carries data for a read accepted OREG+1 cycles earlier
- WE  in  (1<<P_DW)/8  per-byte write enable
- WADDR  in  AW  write address
- DIN  in  1<<P_DW  write data

## Operation
- FSM states: INIT, RUN. Clear counter cnt, AW bits.
- RST asserted (any time, including mid-clear or mid-read): state=INIT, cnt=0, BUSY=1, DOUT=0, DOUT_VALID=0, pipeline registers=0. Array contents not reset directly; cleared by INIT.
- INIT: each cycle writes all-zero to entry cnt (all bytes), cnt<=cnt+1. On the cycle cnt==(1<<AW)-1 the final write occurs and state<=RUN. RE, WE, CLR ignored; DOUT held, DOUT_VALID=0.
- RUN: BUSY=0. CLR=1 -> state<=INIT, cnt<=0 next cycle; any RE/WE in that same cycle is still performed normally (reads complete, DOUT_VALID still pulses).
- Write: for each byte b with WE[b]=1, mem[WADDR] byte b <= DIN byte b; other bytes unchanged. WE=0 -> no write.
- Read: RE=1 captures mem[RADDR] into stage-1 register. Forwarding is write-first, per byte: if WE[b]=1 and WADDR==RADDR in the same cycle, stage-1 byte b takes DIN byte b, other bytes take old contents.
- A write in any later cycle never alters a read already captured.
- RE=0: stage-1 register holds its value (no uncertain/garbage output after writes).
- OREG=0: DOUT = stage-1. OREG=1: stage-2 loads stage-1 every cycle; DOUT = stage-2, so DOUT also holds when reads stop.
- DOUT_VALID: RE&~BUSY delayed by OREG+1 cycles through a valid shift chain; pulse-per-read, not level.
- No address arithmetic; cnt wraps naturally from (1<<AW)-1 only at the INIT->RUN transition.

## Timing
- Reset to first usable cycle: BUSY=1 for exactly 1<<AW cycles after RST release; RE/WE first honoured on edge 1<<AW+1 counted from first edge after release.
- Read latency: RE sampled at edge N -> DOUT/DOUT_VALID valid after edge N+1 (OREG=0) or N+2 (OREG=1).
- Back-to-back reads every cycle supported; throughput one read and one write per cycle.
- CLR accepted at edge N -> BUSY=1 after edge N, state INIT; BUSY falls after edge N+(1<<AW).
- Reads in the valid chain when CLR or BUSY rises still complete their DOUT_VALID pulse; reset drops them.

## Test plan
- Reset clear: P_DW=6, AW=4, OREG=0; pulse RST, hold BUSY for 16 cycles, then read all 16 addresses -> DOUT=0 each, DOUT_VALID one cycle after each RE, BUSY=1 for exactly 16 cycles.
- Byte writes: write 64'h1122334455667788 WE=8'hFF to addr 3, then 64'hAAAA WE=8'h03 to addr 3, read addr 3 -> 64'h112233445566AAAA.
- Forwarding: addr 5 holds 64'h0; same cycle RE RADDR=5, WE=8'hF0 WADDR=5 DIN=64'hDEADBEEF_CAFEF00D -> DOUT=64'hDEADBEEF_00000000; mismatched WADDR=6 -> DOUT=0.
- Hold and latency: OREG=1; read addr 3 at edge N -> DOUT valid after N+2 with DOUT_VALID single pulse; then 5 idle cycles with writes to addr 3 -> DOUT unchanged.
- CLR mid-run: fill addrs 0..15 with index, assert CLR one cycle with concurrent read of addr 7 -> DOUT=7 with DOUT_VALID, BUSY 16 cycles, subsequent reads return 0; RE during BUSY -> no DOUT_VALID.
- Reset mid-clear: assert RST at cnt=9 of INIT -> BUSY stays 1, cnt restarts at 0, BUSY falls exactly 16 cycles after RST release, DOUT=0 throughout.
